// File: rtl/carrier_correlator.sv
// carrier_correlator: I/Q carrier correlator with continuous fixed-length dumps; define CARRIER_CORRELATOR_SATURATE_EN for clamping accumulators
module carrier_correlator #(
  parameter int DATA_BITS_IN = 8,
  parameter int LO_BITS = 8,
  parameter int ACC_BITS = 24,
  parameter int LEN_BITS = 10
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           ena,
  input  logic signed [DATA_BITS_IN-1:0] sample_in,
  input  logic signed [LO_BITS-1:0]      sin_in,
  input  logic signed [LO_BITS-1:0]      cos_in,
  input  logic [LEN_BITS-1:0]            dump_len,
  input  logic                           start,
  input  logic                           stop,
  output logic signed [ACC_BITS-1:0]     i_out,
  output logic signed [ACC_BITS-1:0]     q_out,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           overrun
);
  localparam int PW = DATA_BITS_IN + LO_BITS;
  typedef enum logic {IDLE, INTEGRATE} state_t;
  state_t state, state_nxt;
  logic [LEN_BITS-1:0] len, cnt, last;
  logic signed [ACC_BITS-1:0] i_acc, q_acc, i_prod, q_prod, i_nxt, q_nxt;
  logic go, halt, step, dump, sat_hit;
  assign i_prod = ACC_BITS'(PW'(sample_in) * PW'(cos_in));
  assign q_prod = ACC_BITS'(PW'(sample_in) * PW'(sin_in));
  assign go = ena && state == IDLE && start;
  assign halt = ena && state == INTEGRATE && stop;
  assign step = ena && state == INTEGRATE && !stop;
  assign last = (len == '0) ? '0 : len - 1'b1;
  assign dump = step && cnt == last;
`ifdef CARRIER_CORRELATOR_SATURATE_EN
  logic signed [ACC_BITS:0] i_sum, q_sum;
  logic i_clip, q_clip;
  // One extra bit exposes overflow so the sum can be pinned to the nearest rail
  always_comb begin
    i_sum = {i_acc[ACC_BITS-1], i_acc} + {i_prod[ACC_BITS-1], i_prod};
    q_sum = {q_acc[ACC_BITS-1], q_acc} + {q_prod[ACC_BITS-1], q_prod};
    i_clip = i_sum[ACC_BITS] != i_sum[ACC_BITS-1];
    q_clip = q_sum[ACC_BITS] != q_sum[ACC_BITS-1];
    i_nxt = i_clip ? {i_sum[ACC_BITS], {(ACC_BITS-1){~i_sum[ACC_BITS]}}} : i_sum[ACC_BITS-1:0];
    q_nxt = q_clip ? {q_sum[ACC_BITS], {(ACC_BITS-1){~q_sum[ACC_BITS]}}} : q_sum[ACC_BITS-1:0];
    sat_hit = step && (i_clip || q_clip);
  end
`else
  // Plain two's-complement accumulation, wrapping on overflow
  always_comb begin
    i_nxt = i_acc + i_prod;
    q_nxt = q_acc + q_prod;
    sat_hit = 1'b0;
  end
`endif
  // State register
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // Start enters integration; stop aborts back to idle
  always_comb begin
    state_nxt = go ? INTEGRATE : halt ? IDLE : state;
  end
  // Accumulators, sample counter, dump registers and output handshake
  always_ff @(posedge clk)
    if (!rst_n) begin
      len <= '0;
      cnt <= '0;
      i_acc <= '0;
      q_acc <= '0;
      i_out <= '0;
      q_out <= '0;
      out_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (go) begin
        len <= dump_len;
        cnt <= '0;
        i_acc <= '0;
        q_acc <= '0;
        overrun <= 1'b0;
      end else if (halt) begin
        cnt <= '0;
        i_acc <= '0;
        q_acc <= '0;
      end else if (step) begin
        i_acc <= dump ? '0 : i_nxt;
        q_acc <= dump ? '0 : q_nxt;
        cnt <= dump ? '0 : cnt + 1'b1;
        if (dump) begin
          i_out <= i_nxt;
          q_out <= q_nxt;
        end
        if ((dump && out_valid && !out_ready) || sat_hit) overrun <= 1'b1;
      end
      out_valid <= dump || (out_valid && !out_ready);
    end
endmodule

// File: tb/tb_carrier_correlator.sv
// tb_carrier_correlator: scoreboard bench for carrier_correlator with a behavioural per-window model
module tb_carrier_correlator;
  localparam int DW = 8;
  localparam int LW = 8;
  localparam int AW = 24;
  localparam int NW = 10;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic out_ready = 1'b0;
  logic signed [DW-1:0] sample_in = '0;
  logic signed [LW-1:0] sin_in = '0;
  logic signed [LW-1:0] cos_in = '0;
  logic [NW-1:0] dump_len = '0;
  logic signed [AW-1:0] i_out, q_out;
  logic out_valid, overrun;
  logic rst16_n = 1'b0;
  logic start16 = 1'b0;
  logic signed [15:0] i16, q16;
  logic v16, o16;
  int checks = 0;
  int errors = 0;
  longint exp_i[$], exp_q[$];
  bit m_int, m_valid, m_ovr, e_valid, e_ovr;
  int m_len, m_cnt;
  longint m_i, m_q;

  always #5 clk = ~clk;

  carrier_correlator #(.DATA_BITS_IN(DW), .LO_BITS(LW), .ACC_BITS(AW), .LEN_BITS(NW)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sample_in(sample_in), .sin_in(sin_in), .cos_in(cos_in),
    .dump_len(dump_len), .start(start), .stop(stop), .i_out(i_out), .q_out(q_out),
    .out_valid(out_valid), .out_ready(out_ready), .overrun(overrun));

  carrier_correlator #(.DATA_BITS_IN(8), .LO_BITS(8), .ACC_BITS(16), .LEN_BITS(NW)) dut16 (
    .clk(clk), .rst_n(rst16_n), .ena(1'b1), .sample_in(8'sd127), .sin_in(8'sd127), .cos_in(8'sd127),
    .dump_len(NW'(3)), .start(start16), .stop(1'b0), .i_out(i16), .q_out(q16),
    .out_valid(v16), .out_ready(1'b0), .overrun(o16));

  task automatic chk(string n, longint a, longint e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", n, a, e);
    end
  endtask

  function automatic longint acc_add(longint a, longint p, output bit sat);
    longint s, lo, hi;
    s = a + p;
    lo = -(longint'(1) <<< (AW - 1));
    hi = (longint'(1) <<< (AW - 1)) - 1;
    sat = 1'b0;
`ifdef CARRIER_CORRELATOR_SATURATE_EN
    if (s > hi) begin s = hi; sat = 1'b1; end
    else if (s < lo) begin s = lo; sat = 1'b1; end
`else
    s = s & ((longint'(1) <<< AW) - 1);
    if (s > hi) s = s - (longint'(1) <<< AW);
`endif
    return s;
  endfunction

  task automatic model_step();
    bit nv, si, sq;
    if (!rst_n) begin
      m_int = 0; m_len = 0; m_cnt = 0; m_i = 0; m_q = 0; m_valid = 0; m_ovr = 0;
      exp_i.delete();
      exp_q.delete();
      return;
    end
    nv = m_valid && !out_ready;
    if (ena) begin
      if (!m_int && start) begin
        m_int = 1; m_len = (dump_len == 0) ? 1 : int'(dump_len); m_cnt = 0; m_i = 0; m_q = 0; m_ovr = 0;
      end else if (m_int && stop) begin
        m_int = 0; m_cnt = 0; m_i = 0; m_q = 0;
      end else if (m_int) begin
        m_i = acc_add(m_i, longint'(sample_in) * longint'(cos_in), si);
        m_q = acc_add(m_q, longint'(sample_in) * longint'(sin_in), sq);
        if (si || sq) m_ovr = 1;
        m_cnt++;
        if (m_cnt == m_len) begin
          if (m_valid && !out_ready) begin
            m_ovr = 1;
            void'(exp_i.pop_back());
            void'(exp_q.pop_back());
          end
          exp_i.push_back(m_i);
          exp_q.push_back(m_q);
          nv = 1; m_i = 0; m_q = 0; m_cnt = 0;
        end
      end
    end
    m_valid = nv;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    e_valid = m_valid;
    e_ovr = m_ovr;
    #1;
  endtask

  // Monitor: flags and accepted dumps checked against the scoreboard
  always @(negedge clk)
    if (rst_n) begin
      chk("out_valid", out_valid, e_valid);
      chk("overrun", overrun, e_ovr);
      if (out_valid && out_ready) begin
        if (exp_i.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dump_unexpected got i=%0d q=%0d expected none", i_out, q_out);
        end else begin
          chk("dump_i", i_out, exp_i.pop_front());
          chk("dump_q", q_out, exp_q.pop_front());
        end
      end
    end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst16_n = 1'b1;
    start16 = 1'b1;
    @(posedge clk);
    #1;
    start16 = 1'b0;
    for (int k = 0; k < 10 && !v16; k++) begin
      @(posedge clk);
      #1;
    end
    chk("acc16_valid", v16, 1);
`ifdef CARRIER_CORRELATOR_SATURATE_EN
    chk("acc16_i", i16, 32767);
    chk("acc16_ovr", o16, 1);
`else
    chk("acc16_i", i16, -17149);
    chk("acc16_ovr", o16, 0);
`endif
    cycle();
    chk("rst_i", i_out, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ovr", overrun, 0);
    rst_n = 1'b1; ena = 1'b1; out_ready = 1'b1;
    sample_in = 10; cos_in = 20; sin_in = -5; dump_len = 4; start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (3) cycle();
    chk("len4_early", out_valid, 0);
    cycle();
    chk("len4_valid", out_valid, 1);
    chk("len4_i", i_out, 800);
    chk("len4_q", q_out, -200);
    repeat (4) cycle();
    chk("len4_again_valid", out_valid, 1);
    chk("len4_again_i", i_out, 800);
    stop = 1'b1;
    cycle();
    stop = 1'b0; dump_len = 0; start = 1'b1;
    cycle();
    start = 1'b0; sample_in = -7; cos_in = 9;
    cycle();
    chk("len0_i", i_out, -63);
    sample_in = 100; cos_in = -128;
    cycle();
    chk("len0_i2", i_out, -12800);
    stop = 1'b1;
    cycle();
    stop = 1'b0; dump_len = 2; out_ready = 1'b0; cos_in = 1; start = 1'b1;
    cycle();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      sample_in = DW'(k);
      cycle();
    end
    chk("ovr_set", overrun, 1);
    chk("ovr_i", i_out, 7);
    stop = 1'b1;
    cycle();
    stop = 1'b0; start = 1'b1;
    cycle();
    start = 1'b0;
    chk("ovr_clear", overrun, 0);
    chk("stop_keeps_valid", out_valid, 1);
    rst_n = 1'b0;
    cycle();
    chk("midrst_valid", out_valid, 0);
    chk("midrst_q", q_out, 0);
    rst_n = 1'b1;
    repeat (5) cycle();
    chk("no_dump_after_rst", out_valid, 0);
    for (int c = 0; c < 4000; c++) begin
      rst_n = $urandom_range(0, 399) != 0;
      ena = $urandom_range(0, 9) < 8;
      start = $urandom_range(0, 9) == 0;
      stop = $urandom_range(0, 59) == 0;
      out_ready = $urandom_range(0, 9) < 6;
      sample_in = DW'($urandom);
      sin_in = LW'($urandom);
      cos_in = LW'($urandom);
      dump_len = ($urandom_range(0, 3) == 0) ? NW'($urandom_range(0, 40)) : NW'($urandom_range(0, 5));
      cycle();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
